// File: rtl/svc_rv_div_arb_pkg.sv
// Shared types for the divider arbiter: FSM state encoding and the RV32M
// funct3 codes carried on req_op / div_op.
package svc_rv_div_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } div_arb_state_e;

   localparam logic [2:0] OP_DIV  = 3'b100;
   localparam logic [2:0] OP_DIVU = 3'b101;
   localparam logic [2:0] OP_REM  = 3'b110;
   localparam logic [2:0] OP_REMU = 3'b111;

endpackage

// File: rtl/svc_rr_arb.sv
// Round-robin grant for NUM_REQ requesters.
// Ports:
//   req   - request vector
//   ptr   - index holding highest priority this cycle
//   grant - one-hot grant (all zero when no request)
module svc_rr_arb #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant
);

   logic [IDX_W:0] idx;
   logic           found;

   // Scan from ptr upward, wrapping at NUM_REQ; first hit wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, ptr} + (IDX_W+1)'(i);
         if (idx >= (IDX_W+1)'(NUM_REQ)) begin
            idx = idx - (IDX_W+1)'(NUM_REQ);
         end
         if (!found && req[idx[IDX_W-1:0]]) begin
            grant[idx[IDX_W-1:0]] = 1'b1;
            found                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/svc_rv_div_arb.sv
// Shares one iterative divider among NUM_REQ requesters, one operation at a
// time. Default build uses fixed priority (lowest index wins); defining
// SVC_RV_DIV_ARB_RR_EN switches to round-robin via svc_rr_arb.
// Ports:
//   clk, rst                     - clock, async active-high reset
//   req_valid/ready/rs1/rs2/op   - per-requester request channel (flattened)
//   resp_valid/ready, resp_result - per-requester response, shared result bus
//   div_en/rs1/rs2/op            - divider start pulse and held operands
//   div_busy, div_result         - divider status and combinational result
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no op in flight; grant any valid requester
// ST_ISSUE | pulse div_en with latched operands
// ST_WAIT  | wait for div_busy low, capture div_result
// ST_RESP  | present result to owner until its resp_ready
module svc_rv_div_arb
   import svc_rv_div_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_rs1,
   input  logic [NUM_REQ*WIDTH-1:0] req_rs2,
   input  logic [NUM_REQ*3-1:0]     req_op,
   output logic [NUM_REQ-1:0]       resp_valid,
   input  logic [NUM_REQ-1:0]       resp_ready,
   output logic [WIDTH-1:0]         resp_result,
   output logic                     div_en,
   output logic [WIDTH-1:0]         div_rs1,
   output logic [WIDTH-1:0]         div_rs2,
   output logic [2:0]               div_op,
   input  logic                     div_busy,
   input  logic [WIDTH-1:0]         div_result
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   div_arb_state_e     state_q, state_d;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx, owner_q;
   logic [WIDTH-1:0]   sel_rs1, sel_rs2, rs1_q, rs2_q, result_q;
   logic [2:0]         sel_op, op_q;
   logic               grant_fire, owner_ack;

   assign grant_fire = (state_q == ST_IDLE) && (|req_valid);

`ifdef SVC_RV_DIV_ARB_RR_EN
   logic [IDX_W-1:0] rr_ptr_q;

   svc_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arb (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else if (grant_fire) begin
         rr_ptr_q <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end
`else
   logic fp_found;

   always_comb begin
      grant    = '0;
      fp_found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && !fp_found) begin
            grant[i] = 1'b1;
            fp_found = 1'b1;
         end
      end
   end
`endif

   // One-hot grant to index, plus operand mux for the winner.
   always_comb begin
      grant_idx = '0;
      sel_rs1   = '0;
      sel_rs2   = '0;
      sel_op    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            grant_idx = IDX_W'(i);
            sel_rs1   = req_rs1[i*WIDTH +: WIDTH];
            sel_rs2   = req_rs2[i*WIDTH +: WIDTH];
            sel_op    = req_op[i*3 +: 3];
         end
      end
   end

   always_comb begin
      resp_valid = '0;
      if (state_q == ST_RESP) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = (owner_q == IDX_W'(i));
         end
      end
   end

   assign owner_ack = |(resp_ready & resp_valid);

   always_comb begin
      state_d     = state_q;
      req_ready   = '0;
      div_en      = 1'b0;
      resp_result = '0;
      case (state_q)
         ST_IDLE: begin
            if (grant_fire) begin
               req_ready = grant;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            div_en  = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (!div_busy) state_d = ST_RESP;
         end
         ST_RESP: begin
            resp_result = result_q;
            if (owner_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         op_q     <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (grant_fire) begin
            owner_q <= grant_idx;
            rs1_q   <= sel_rs1;
            rs2_q   <= sel_rs2;
            op_q    <= sel_op;
         end
         if ((state_q == ST_WAIT) && !div_busy) begin
            result_q <= div_result;
         end
      end
   end

   // Operands stay on the divider pins until the next grant, so the op the
   // divider uses to pick quotient vs remainder is stable at capture.
   assign div_rs1 = rs1_q;
   assign div_rs2 = rs2_q;
   assign div_op  = op_q;

endmodule
